divider_share_scheduler: RTL and testbench
==========================================

Name: divider_share_scheduler

Overview:
- Time-shares one pipelined fixed-latency divider (dividend/divisor in, 38-bit quotient out) among N_REQ requesters, e.g. per-axis speed computations (constant / speed count).
- Round-robin grants one request per enabled cycle and drives the divider operands.
- Tracks in-flight requester IDs through a tag pipeline matched to the divider latency, then routes each quotient back to its originating requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- OP_W, 32, dividend/divisor width.
- RES_W, 38, divider quotient width.
- DIV_LATENCY, 8, divider latency in ce_1 cycles from operand-valid to quotient-valid (>=1).

Ports:
- clk_1  in  1  system clock.
- clr  in  1  asynchronous, active-high reset.
- ce_1  in  1  clock enable; all state advances only when high.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant; one-hot or zero.
- req_a  in  N_REQ*OP_W  packed dividends; requester i at bits [i*OP_W +: OP_W].
- req_b  in  N_REQ*OP_W  packed divisors; same packing.
- div_a  out  OP_W  divider dividend, registered.
- div_b  out  OP_W  divider divisor, registered.
- div_tvalid  out  1  divider operand valid, registered.
- div_op  in  RES_W  divider quotient.
- rsp_valid  out  N_REQ  one-hot response strobe, registered.
- rsp_data  out  RES_W  quotient for the strobed requester, registered.
- busy  out  1  high while any tag is in flight.

Behaviour:
- Reset (clr=1, async): req_ready=0, div_a=0, div_b=0, div_tvalid=0, rsp_valid=0, rsp_data=0, busy=0.
  - Also cleared: round-robin pointer=0, all pending flags, all tags.
- Reset mid-operation: in-flight quotients are discarded and no rsp_valid follows. Divider internal state is ignored because the tags are cleared.
- Handshake: transfer occurs when req_valid[i] & req_ready[i] & ce_1.
  - req_ready is combinational from req_valid, pointer, pending and ce_1.
  - req_ready=0 whenever ce_1=0.
- One outstanding per requester: pending[i] sets on transfer and clears on requester i's rsp_valid. Requester i is not eligible while pending[i]=1.
  - Same-cycle response for i and new request from i: the new request is not granted that cycle (pending is still 1).
- Arbitration: search from pointer upward, with wrap, for the first eligible requester.
  - On grant to k, the pointer becomes (k+1) mod N_REQ.
  - With no grant, the pointer holds.
- Issue: at a transfer in ce-cycle t, div_a/div_b take that requester's operands and div_tvalid=1 during t+1.
  - With no transfer, div_tvalid=0 and div_a/div_b hold their previous values.
- Tag pipeline: DIV_LATENCY stages of {valid, id}, aligned so the last stage is valid when div_op is the quotient for that id, i.e. ce-cycle t+1+DIV_LATENCY.
- Response: registered, so rsp_valid[id]=1 and rsp_data=div_op in ce-cycle t+2+DIV_LATENCY.
  - Total latency from handshake to response = DIV_LATENCY+2 ce cycles.
  - rsp_valid is a single-cycle strobe. No backpressure; the requester must accept it.
  - rsp_data holds its value between strobes.
- ce_1=0: every register holds, including the tag pipeline and rsp_valid. The divider must share the same ce_1 so alignment is preserved.
- busy = OR of tag valids, div_tvalid and rsp_valid.
- Throughput: one issue per enabled cycle. Worst-case wait for a continuously valid, non-pending requester is N_REQ-1 grants.

Optional Feature:
- Macro: DIV_SHARE_ZERO_GUARD_EN.
- Defined:
  - Adds a zero flag to each tag, set when the issued divisor is 0.
  - On response, rsp_data is forced to the positive saturation value {1'b0, {RES_W-1{1'b1}}} instead of div_op.
  - Adds output div_zero (1 bit, registered, reset 0), pulsed together with that rsp_valid.
- Undefined: no flag and no port; rsp_data = div_op unconditionally.

Decomposition:
- Package divider_share_pkg: default widths; function rr_pick(valid_mask, pointer) returning {found, index}; the tag struct {valid, id[$clog2(N_REQ)-1:0], zero}.
- One sub-module, divider_share_tag_pipe: parameterized-depth shift register of tags with ce and async clr.

Test Plan:
- Single request, DIV_LATENCY=8:
  - req_valid[2]=1 with a=1000, b=10 at cycle 0 gives req_ready[2]=1 at cycle 0 and div_tvalid=1 with div_a=1000, div_b=10 at cycle 1.
  - With the model returning div_op=100<<6, rsp_valid=4'b0100 and rsp_data=6400 at cycle 10.
- All four requesters valid continuously: grants in order 0,1,2,3, each requester held pending. Requester 0 is re-granted only after its response, i.e. the cycle after its rsp_valid.
- ce_1 toggled 1,0,1,0 during flight: the response arrives after exactly 10 enabled cycles. All outputs hold while ce_1=0.
- clr asserted 4 cycles after issue: all outputs go to 0 immediately, no rsp_valid is ever produced, and requester pending is cleared (re-grant on the next enabled cycle).
- Response to requester 1 coincides with a new req_valid[1]: no grant to 1 that cycle; it is granted the next enabled cycle.
- With DIV_SHARE_ZERO_GUARD_EN and b=0 for requester 3: rsp_data=38'h1F_FFFF_FFFF, and div_zero=1 in the same cycle as rsp_valid[3].

Source files
------------

// File: rtl/divider_share_pkg.sv
// Shared widths, tag layout and round-robin helper for the divider share scheduler.
// Optional zero-divisor guard is enabled with DIV_SHARE_ZERO_GUARD_EN.
package divider_share_pkg;

    localparam int N_REQ_DEF       = 4;
    localparam int OP_W_DEF        = 32;
    localparam int RES_W_DEF       = 38;
    localparam int DIV_LATENCY_DEF = 8;

    // Tag ids are sized for the largest supported requester count.
    localparam int MAX_REQ = 8;
    localparam int ID_W    = $clog2(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            zero;
    } tag_t;

    // Returns {found, index}: first set bit of mask at or above ptr, wrapping at n.
    function automatic logic [ID_W:0] rr_pick(
        input logic [MAX_REQ-1:0] mask,
        input logic [ID_W-1:0]    ptr,
        input int                 n
    );
        logic            found;
        logic [ID_W-1:0] idx;
        int              k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            k = (int'(ptr) + i) % n;
            if (!found && i < n && mask[k]) begin
                found = 1'b1;
                idx   = k[ID_W-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/divider_share_scheduler_if.sv
// Requester and divider-side signal bundle of the divider share scheduler.
// div_zero exists only when DIV_SHARE_ZERO_GUARD_EN is defined.
interface divider_share_scheduler_if
    import divider_share_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int OP_W  = OP_W_DEF,
    parameter int RES_W = RES_W_DEF
);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*OP_W-1:0] req_a;
    logic [N_REQ*OP_W-1:0] req_b;
    logic [OP_W-1:0]       div_a;
    logic [OP_W-1:0]       div_b;
    logic                  div_tvalid;
    logic [RES_W-1:0]      div_op;
    logic [N_REQ-1:0]      rsp_valid;
    logic [RES_W-1:0]      rsp_data;
`ifdef DIV_SHARE_ZERO_GUARD_EN
    logic                  div_zero;
`endif

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  div_op,
        output req_ready,
        output div_a,
        output div_b,
        output div_tvalid,
        output rsp_valid,
        output rsp_data
`ifdef DIV_SHARE_ZERO_GUARD_EN
        ,
        output div_zero
`endif
    );

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output div_op,
        input  req_ready,
        input  div_a,
        input  div_b,
        input  div_tvalid,
        input  rsp_valid,
        input  rsp_data
`ifdef DIV_SHARE_ZERO_GUARD_EN
        ,
        input  div_zero
`endif
    );

endinterface

// File: rtl/divider_share_tag_pipe.sv
// Fixed-depth tag shift register that tracks in-flight divider requests.
// Advances only on ce; cleared asynchronously by clr.
module divider_share_tag_pipe
    import divider_share_pkg::*;
#(
    parameter int DEPTH = DIV_LATENCY_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic ce,
    input  tag_t din,
    output tag_t dout,
    output logic any_valid
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (ce) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i].valid;
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/divider_share_scheduler.sv
// Round-robin time-sharing of one pipelined divider with quotient routing by tag.
// DIV_SHARE_ZERO_GUARD_EN saturates quotients of zero divisors and adds div_zero.
module divider_share_scheduler
    import divider_share_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int OP_W        = OP_W_DEF,
    parameter int RES_W       = RES_W_DEF,
    parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
    input  logic clk_1,
    input  logic clr,
    input  logic ce_1,
    divider_share_scheduler_if.slave bus,
    output logic busy
);

    logic [ID_W-1:0]    ptr;
    logic [N_REQ-1:0]   pending;
    logic [MAX_REQ-1:0] elig;
    logic [ID_W:0]      pick;
    logic [ID_W-1:0]    gidx;
    logic               grant;
    logic [N_REQ-1:0]   gnt_oh;
    logic [OP_W-1:0]    sel_a;
    logic [OP_W-1:0]    sel_b;

    logic [OP_W-1:0]    div_a_q;
    logic [OP_W-1:0]    div_b_q;
    logic               tvalid_q;
    logic [ID_W-1:0]    issue_id;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [RES_W-1:0]   rsp_data_q;
    logic [N_REQ-1:0]   rsp_oh;

    tag_t               tag_in;
    tag_t               tag_out;
    logic               tags_busy;

`ifdef DIV_SHARE_ZERO_GUARD_EN
    logic               issue_zero;
    logic               div_zero_q;
`else
    logic               unused_zero;
    assign unused_zero = tag_out.zero;
`endif

    always_comb begin
        elig = '0;
        elig[N_REQ-1:0] = bus.req_valid & ~pending;
        pick   = rr_pick(elig, ptr, N_REQ);
        gidx   = pick[ID_W-1:0];
        grant  = pick[ID_W] & ce_1 & ~clr;
        gnt_oh = grant ? (N_REQ'(1) << gidx) : '0;
        sel_a  = bus.req_a[int'(gidx)*OP_W +: OP_W];
        sel_b  = bus.req_b[int'(gidx)*OP_W +: OP_W];
        rsp_oh = N_REQ'(1) << tag_out.id;
    end

    always_ff @(posedge clk_1 or posedge clr) begin
        if (clr) begin
            ptr         <= '0;
            pending     <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            tvalid_q    <= 1'b0;
            issue_id    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else if (ce_1) begin
            tvalid_q <= grant;
            // A response frees its requester only from the next cycle on.
            pending  <= (pending | gnt_oh) & ~rsp_valid_q;
            if (grant) begin
                ptr      <= (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
                div_a_q  <= sel_a;
                div_b_q  <= sel_b;
                issue_id <= gidx;
            end
            rsp_valid_q <= tag_out.valid ? rsp_oh : '0;
            if (tag_out.valid) begin
`ifdef DIV_SHARE_ZERO_GUARD_EN
                rsp_data_q <= tag_out.zero ?
                              {1'b0, {(RES_W-1){1'b1}}} : bus.div_op;
`else
                rsp_data_q <= bus.div_op;
`endif
            end
        end
    end

`ifdef DIV_SHARE_ZERO_GUARD_EN
    always_ff @(posedge clk_1 or posedge clr) begin
        if (clr) begin
            issue_zero <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (ce_1) begin
            if (grant) issue_zero <= (sel_b == '0);
            div_zero_q <= tag_out.valid & tag_out.zero;
        end
    end

    assign bus.div_zero = div_zero_q;
`endif

    // Tags enter alongside div_tvalid so the last stage lines up with div_op.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = tvalid_q;
        tag_in.id    = issue_id;
`ifdef DIV_SHARE_ZERO_GUARD_EN
        tag_in.zero  = issue_zero;
`endif
    end

    divider_share_tag_pipe #(
        .DEPTH(DIV_LATENCY)
    ) u_tags (
        .clk       (clk_1),
        .clr       (clr),
        .ce        (ce_1),
        .din       (tag_in),
        .dout      (tag_out),
        .any_valid (tags_busy)
    );

    assign bus.req_ready  = gnt_oh;
    assign bus.div_a      = div_a_q;
    assign bus.div_b      = div_b_q;
    assign bus.div_tvalid = tvalid_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign busy = tags_busy | tvalid_q | (|rsp_valid_q);

endmodule

// File: tb/tb_divider_share_scheduler.sv
// Bench for divider_share_scheduler with a pipelined divider model and scoreboard.
// Define DIV_SHARE_ZERO_GUARD_EN to also exercise the zero-divisor guard.
module tb_divider_share_scheduler;

    localparam int N = 4;
    localparam int W = 32;
    localparam int R = 38;
    localparam int L = 8;

    logic clk = 1'b0;
    logic clr;
    logic ce;
    logic busy;

    always #5 clk = ~clk;

    divider_share_scheduler_if #(.N_REQ(N), .OP_W(W), .RES_W(R)) bus ();

    divider_share_scheduler #(
        .N_REQ(N), .OP_W(W), .RES_W(R), .DIV_LATENCY(L)
    ) dut (
        .clk_1 (clk),
        .clr   (clr),
        .ce_1  (ce),
        .bus   (bus),
        .busy  (busy)
    );

    // Divider model: quotient with 6 fractional bits, L enabled cycles of latency.
    function automatic logic [R-1:0] q_of(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [R-1:0] n;
        logic [R-1:0] d;
        if (b == '0) return '1;
        n = {a, 6'b0};
        d = {6'b0, b};
        return n / d;
    endfunction

    function automatic logic [R-1:0] exp_of(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_SHARE_ZERO_GUARD_EN
        if (b == '0) return {1'b0, {(R-1){1'b1}}};
`endif
        return q_of(a, b);
    endfunction

    logic [R-1:0] mpipe [L];

    always @(posedge clk) begin
        if (ce) begin
            mpipe[0] <= bus.div_tvalid ? q_of(bus.div_a, bus.div_b) : '0;
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end
    end

    assign bus.div_op = mpipe[L-1];

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int           id;
        logic [R-1:0] q;
        int           due;
        logic         z;
    } sb_t;

    sb_t sb[$];

    always @(posedge clk) if (ce && !clr) ecnt <= ecnt + 1;

    always @(negedge clk) begin
        if (clr) begin
            sb.delete();
        end else if (ce) begin
            if (bus.rsp_valid != '0) chk("rsp_onehot", 128'($onehot(bus.rsp_valid)), 1);
            for (int i = 0; i < N; i++) begin
                if (bus.rsp_valid[i]) begin
                    int k;
                    k = -1;
                    for (int j = 0; j < sb.size(); j++)
                        if (k < 0 && sb[j].id == i) k = j;
                    if (k < 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rsp_unexpected: requester %0d strobed, none outstanding", i);
                    end else begin
                        chk("rsp_due", 128'(ecnt), 128'(sb[k].due));
                        chk("rsp_data", bus.rsp_data, sb[k].q);
`ifdef DIV_SHARE_ZERO_GUARD_EN
                        chk("rsp_div_zero", bus.div_zero, sb[k].z);
`endif
                        sb.delete(k);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i])
                    sb.push_back('{i, exp_of(bus.req_a[i*W +: W], bus.req_b[i*W +: W]),
                                   ecnt + L + 2, bus.req_b[i*W +: W] == '0});
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        smp();
        nxt();
        clr = 1'b0;
    endtask

    task automatic wait_rsp(input int id, input int limit, output int n_en);
        bit hit;
        hit  = 1'b0;
        n_en = 0;
        for (int k = 0; k < limit && !hit; k++) begin
            nxt();
            smp();
            if (ce) begin
                n_en++;
                if (bus.rsp_valid[id]) hit = 1'b1;
            end
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_rsp: no response for requester %0d within %0d cycles", id, limit);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        smp();
        while (busy && k < 40) begin
            nxt();
            smp();
            k++;
        end
        chk("drain_busy", busy, 0);
        chk("drain_sb_empty", 128'(sb.size()), 0);
        nxt();
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [R-1:0] q;
    } vec_t;

    vec_t tv [6];

    logic [N-1:0]   all_exp;
    logic [127:0]   snap;
    logic [127:0]   prev_snap;
    bit             prev_ce;
    bit             done;
    int             n_en;
    int             n_rsp;
    int             at;

    initial begin
        tv[0] = '{2, 32'd1000,       32'd10,   38'd6400};
        tv[1] = '{0, 32'd7,          32'd2,    38'd224};
        tv[2] = '{1, 32'hFFFF_FFFF,  32'd1,    38'h3F_FFFF_FFC0};
        tv[3] = '{3, 32'd1,          32'd3,    38'd21};
        tv[4] = '{1, 32'd100,        32'd7,    38'd914};
        tv[5] = '{0, 32'd5,          32'd5000, 38'd0};

        clr = 1'b1;
        ce  = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        nxt();
        nxt();
        bus.req_valid = '1;
        ce = 1'b1;
        smp();
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_div_a", bus.div_a, 0);
        chk("rst_div_b", bus.div_b, 0);
        chk("rst_div_tvalid", bus.div_tvalid, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_busy", busy, 0);
`ifdef DIV_SHARE_ZERO_GUARD_EN
        chk("rst_div_zero", bus.div_zero, 0);
`endif
        nxt();
        clr = 1'b0;
        bus.req_valid = '0;

        for (int v = 0; v < 6; v++) begin
            set_req(tv[v].id, tv[v].a, tv[v].b);
            bus.req_valid = N'(1) << tv[v].id;
            smp();
            chk("tv_ready", bus.req_ready, N'(1) << tv[v].id);
            nxt();
            bus.req_valid = '0;
            smp();
            chk("tv_tvalid", bus.div_tvalid, 1);
            chk("tv_div_a", bus.div_a, tv[v].a);
            chk("tv_div_b", bus.div_b, tv[v].b);
            chk("tv_busy", busy, 1);
            wait_rsp(tv[v].id, 20, n_en);
            chk("tv_latency", 128'(n_en), 128'(L + 1));
            chk("tv_rsp_valid", bus.rsp_valid, N'(1) << tv[v].id);
            chk("tv_rsp_data", bus.rsp_data, tv[v].q);
            chk("tv_tvalid_low", bus.div_tvalid, 0);
            chk("tv_div_a_hold", bus.div_a, tv[v].a);
            nxt();
            smp();
            chk("tv_strobe_end", bus.rsp_valid, 0);
            chk("tv_data_hold", bus.rsp_data, tv[v].q);
            chk("tv_idle", busy, 0);
            nxt();
        end

        pulse_clr();
        for (int i = 0; i < N; i++) set_req(i, 32'(1000 * (i + 1)), 32'(i + 3));
        bus.req_valid = '1;
        for (int c = 0; c < 16; c++) begin
            smp();
            if (c < 4) all_exp = N'(1) << c;
            else if (c >= 11 && c < 15) all_exp = N'(1) << (c - 11);
            else all_exp = '0;
            chk("rr_ready", bus.req_ready, all_exp);
            if (c == 10) chk("rr_rsp0", bus.rsp_valid, 4'b0001);
            nxt();
        end
        bus.req_valid = '0;
        drain();

        pulse_clr();
        set_req(1, 32'd500, 32'd4);
        bus.req_valid = 4'b0010;
        smp();
        chk("ce_ready", bus.req_ready, 4'b0010);
        nxt();
        bus.req_valid = '0;
        prev_ce = 1'b1;
        prev_snap = '0;
        n_en = 0;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            ce = (k % 2 == 1);
            if (k == 0) begin
                set_req(3, 32'd77, 32'd7);
                bus.req_valid = 4'b1000;
            end else begin
                bus.req_valid = '0;
            end
            smp();
            if (k == 0) chk("ce_low_ready", bus.req_ready, 0);
            snap = {bus.div_tvalid, bus.div_a, bus.rsp_valid, bus.rsp_data, busy};
            if (!prev_ce) chk("ce_hold", snap, prev_snap);
            prev_snap = snap;
            prev_ce = ce;
            if (ce) begin
                n_en++;
                if (bus.rsp_valid[1]) begin
                    done = 1'b1;
                    chk("ce_rsp_data", bus.rsp_data, 38'd8000);
                end
            end
            nxt();
        end
        chk("ce_done", 128'(done), 1);
        chk("ce_latency", 128'(n_en), 128'(L + 2));
        ce = 1'b1;
        bus.req_valid = '0;
        drain();

        pulse_clr();
        set_req(2, 32'd90, 32'd9);
        bus.req_valid = 4'b0100;
        smp();
        chk("clr_ready", bus.req_ready, 4'b0100);
        nxt();
        bus.req_valid = '0;
        repeat (3) begin
            smp();
            nxt();
        end
        clr = 1'b1;
        #1;
        chk("clr_busy", busy, 0);
        chk("clr_tvalid", bus.div_tvalid, 0);
        chk("clr_div_a", bus.div_a, 0);
        chk("clr_div_b", bus.div_b, 0);
        chk("clr_rsp_valid", bus.rsp_valid, 0);
        chk("clr_rsp_data", bus.rsp_data, 0);
        smp();
        nxt();
        clr = 1'b0;
        set_req(2, 32'd33, 32'd3);
        bus.req_valid = 4'b0100;
        smp();
        chk("clr_regrant", bus.req_ready, 4'b0100);
        nxt();
        bus.req_valid = '0;
        n_rsp = 0;
        at = 0;
        for (int k = 1; k <= 14; k++) begin
            smp();
            if (bus.rsp_valid[2]) begin
                n_rsp++;
                at = k;
                chk("clr_new_data", bus.rsp_data, 38'd704);
            end
            nxt();
        end
        chk("clr_rsp_count", 128'(n_rsp), 1);
        chk("clr_rsp_at", 128'(at), 128'(L + 2));
        drain();

        pulse_clr();
        set_req(1, 32'd64, 32'd8);
        bus.req_valid = 4'b0010;
        smp();
        chk("same_ready", bus.req_ready, 4'b0010);
        nxt();
        bus.req_valid = '0;
        for (int k = 1; k <= L + 1; k++) begin
            smp();
            nxt();
        end
        set_req(1, 32'd640, 32'd8);
        bus.req_valid = 4'b0010;
        smp();
        chk("same_rsp", bus.rsp_valid, 4'b0010);
        chk("same_rsp_data", bus.rsp_data, 38'd512);
        chk("same_no_grant", bus.req_ready, 0);
        nxt();
        smp();
        chk("same_next_grant", bus.req_ready, 4'b0010);
        nxt();
        bus.req_valid = '0;
        drain();

`ifdef DIV_SHARE_ZERO_GUARD_EN
        pulse_clr();
        set_req(3, 32'd12345, 32'd0);
        bus.req_valid = 4'b1000;
        smp();
        chk("zero_ready", bus.req_ready, 4'b1000);
        nxt();
        bus.req_valid = '0;
        smp();
        wait_rsp(3, 20, n_en);
        chk("zero_rsp_data", bus.rsp_data, 38'h1F_FFFF_FFFF);
        chk("zero_flag", bus.div_zero, 1);
        nxt();
        smp();
        chk("zero_flag_end", bus.div_zero, 0);
        nxt();
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
